// File: rtl/alu_defs.sv
// Shared ALU opcode constants and frame-controller state encodings.
package alu_defs;

    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_NOR = 6'b100111;
    localparam logic [5:0] OP_SRL = 6'b000010;
    localparam logic [5:0] OP_SRA = 6'b000011;

    localparam logic [2:0] ST_WAIT_A  = 3'd0;
    localparam logic [2:0] ST_WAIT_B  = 3'd1;
    localparam logic [2:0] ST_WAIT_OP = 3'd2;
    localparam logic [2:0] ST_EXEC    = 3'd3;
    localparam logic [2:0] ST_SEND    = 3'd4;

endpackage

// File: rtl/alu.sv
// Combinational ALU: arithmetic, logic and shift of operand A by operand B.
module alu
    import alu_defs::*;
#(
    parameter int SIZEDATA = 8,
    parameter int SIZEOP   = 6
) (
    input  logic [SIZEDATA-1:0] a_i,
    input  logic [SIZEDATA-1:0] b_i,
    input  logic [SIZEOP-1:0]   op_i,
    output logic [SIZEDATA-1:0] result_o
);

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
        result_o = '0;
        case (op_i)
            OP_ADD:  result_o = a_i + b_i;
            OP_SUB:  result_o = a_i - b_i;
            OP_AND:  result_o = a_i & b_i;
            OP_OR:   result_o = a_i | b_i;
            OP_XOR:  result_o = a_i ^ b_i;
            OP_NOR:  result_o = ~(a_i | b_i);
            OP_SRL:  result_o = a_i >> b_i;
            OP_SRA:  result_o = $unsigned($signed(a_i) >>> b_i);
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/frame_timer.sv
// Inter-byte idle counter; saturates at TIMEOUT-1 and flags expiry there.
module frame_timer #(
    parameter int TIMEOUT = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int            CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign expired = (count_q == LAST);

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && !expired) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: registers are written with <= so every flop samples pre-edge values, independent of statement order.
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/alu_frame_ctrl.sv
// Collects A/B/OP byte frames, drives the ALU, and hands its result to the transmitter.
module alu_frame_ctrl
    import alu_defs::*;
#(
    parameter int SIZEDATA = 8,
    parameter int SIZEOP   = 6,
    parameter int TIMEOUT  = 1000
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic [SIZEDATA-1:0] RX_DATA,
    input  logic                RX_VALID,
    input  logic [SIZEDATA-1:0] RESULT,
    output logic [SIZEDATA-1:0] DATOA,
    output logic [SIZEDATA-1:0] DATOB,
    output logic [SIZEOP-1:0]   OPCODE,
    output logic [SIZEDATA-1:0] TX_DATA,
    output logic                TX_START,
    input  logic                TX_READY,
    output logic                BUSY,
    output logic                OVERRUN,
    output logic                TIMEOUT_ERR
);

    logic [2:0]          state_q, state_d;
    logic [SIZEDATA-1:0] data_a_q, data_a_d;
    logic [SIZEDATA-1:0] data_b_q, data_b_d;
    logic [SIZEOP-1:0]   opcode_q, opcode_d;
    logic [SIZEDATA-1:0] tx_data_q, tx_data_d;
    logic                overrun_q, overrun_d;
    logic                timeout_err_q, timeout_err_d;
    logic                in_gap, rx_accept, expired;

    assign in_gap    = (state_q == ST_WAIT_B) || (state_q == ST_WAIT_OP);
    assign rx_accept = RX_VALID && (in_gap || (state_q == ST_WAIT_A));

    frame_timer #(.TIMEOUT(TIMEOUT)) u_frame_timer (
        .clk     (CLK),
        .reset   (RESET),
        .clear   (rx_accept),
        .enable  (in_gap),
        .expired (expired)
    );

    always_comb begin
        state_d       = state_q;
        data_a_d      = data_a_q;
        data_b_d      = data_b_q;
        opcode_d      = opcode_q;
        tx_data_d     = tx_data_q;
        overrun_d     = 1'b0;
        timeout_err_d = 1'b0;
        case (state_q)
            ST_WAIT_A: begin
                if (RX_VALID) begin
                    data_a_d = RX_DATA;
                    state_d  = ST_WAIT_B;
                end
            end
            ST_WAIT_B: begin
                if (RX_VALID) begin
                    data_b_d = RX_DATA;
                    state_d  = ST_WAIT_OP;
                end else if (expired) begin
                    state_d       = ST_WAIT_A;
                    timeout_err_d = 1'b1;
                end
            end
            ST_WAIT_OP: begin
                if (RX_VALID) begin
                    opcode_d = RX_DATA[SIZEOP-1:0];
                    state_d  = ST_EXEC;
                end else if (expired) begin
                    state_d       = ST_WAIT_A;
                    timeout_err_d = 1'b1;
                end
            end
            ST_EXEC: begin
                tx_data_d = RESULT;
                overrun_d = RX_VALID;
                state_d   = ST_SEND;
            end
            ST_SEND: begin
                overrun_d = RX_VALID;
                if (TX_READY) begin
                    state_d = ST_WAIT_A;
                end
            end
            default: state_d = ST_WAIT_A;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q       <= ST_WAIT_A;
            data_a_q      <= '0;
            data_b_q      <= '0;
            opcode_q      <= '0;
            tx_data_q     <= '0;
            overrun_q     <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            data_a_q      <= data_a_d;
            data_b_q      <= data_b_d;
            opcode_q      <= opcode_d;
            tx_data_q     <= tx_data_d;
            overrun_q     <= overrun_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    // Start is gated by RESET so a reset landing in SEND never emits a request.
    assign TX_START    = (state_q == ST_SEND) && TX_READY && !RESET;
    assign BUSY        = (state_q != ST_WAIT_A);
    assign DATOA       = data_a_q;
    assign DATOB       = data_b_q;
    assign OPCODE      = opcode_q;
    assign TX_DATA     = tx_data_q;
    assign OVERRUN     = overrun_q;
    assign TIMEOUT_ERR = timeout_err_q;

endmodule

// File: tb/tb_alu_frame_ctrl.sv
// Bench for alu_frame_ctrl driving a real ALU; a frame-level model is compared every cycle.
module tb_alu_frame_ctrl;

    localparam int TIMEOUT = 8;

    logic       clk;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_ready;
    logic [7:0] result, datoa, datob, tx_data;
    logic [5:0] opcode;
    logic       tx_start, busy, overrun, timeout_err;

    int n_checks = 0;
    int n_fail   = 0;
    bit en_cmp   = 0;

    alu_frame_ctrl #(.SIZEDATA(8), .SIZEOP(6), .TIMEOUT(TIMEOUT)) dut (
        .CLK         (clk),
        .RESET       (reset),
        .RX_DATA     (rx_data),
        .RX_VALID    (rx_valid),
        .RESULT      (result),
        .DATOA       (datoa),
        .DATOB       (datob),
        .OPCODE      (opcode),
        .TX_DATA     (tx_data),
        .TX_START    (tx_start),
        .TX_READY    (tx_ready),
        .BUSY        (busy),
        .OVERRUN     (overrun),
        .TIMEOUT_ERR (timeout_err)
    );

    alu #(.SIZEDATA(8), .SIZEOP(6)) u_alu (
        .a_i      (datoa),
        .b_i      (datob),
        .op_i     (opcode),
        .result_o (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
        case (op)
            6'h20:   return a + b;
            6'h22:   return a - b;
            6'h24:   return a & b;
            6'h25:   return a | b;
            6'h26:   return a ^ b;
            6'h27:   return ~(a | b);
            6'h02:   return a >> b;
            6'h03:   return $unsigned($signed(a) >>> b);
            default: return 8'h00;
        endcase
    endfunction

    // Frame-level model: bytes held so far, post-frame phase (1 = exec, 2 = send), idle gap length.
    int         m_got = 0, m_post = 0, m_idle = 0;
    logic [7:0] m_a = 0, m_b = 0, m_txd = 0;
    logic [5:0] m_op = 0;
    logic       m_ovr = 0, m_terr = 0;

    initial forever begin
        @(posedge clk);
        if (reset) begin
            m_got = 0; m_post = 0; m_idle = 0;
            m_a = 0; m_b = 0; m_op = 0; m_txd = 0; m_ovr = 0; m_terr = 0;
        end else begin
            m_ovr  = rx_valid && (m_post != 0);
            m_terr = 0;
            if (m_post == 2) begin
                if (tx_ready) m_post = 0;
            end else if (m_post == 1) begin
                m_txd  = alu_ref(m_a, m_b, m_op);
                m_post = 2;
            end else if (rx_valid) begin
                if (m_got == 0) begin
                    m_a = rx_data; m_got = 1;
                end else if (m_got == 1) begin
                    m_b = rx_data; m_got = 2;
                end else begin
                    m_op = rx_data[5:0]; m_got = 0; m_post = 1;
                end
                m_idle = 0;
            end else if (m_got > 0) begin
                m_idle++;
                if (m_idle == TIMEOUT) begin
                    m_got = 0; m_idle = 0; m_terr = 1;
                end
            end
        end
    end

    bit prev_start = 0;
    initial forever begin
        @(negedge clk);
        if (en_cmp) begin
            check("cyc DATOA",       32'(datoa),       32'(m_a));
            check("cyc DATOB",       32'(datob),       32'(m_b));
            check("cyc OPCODE",      32'(opcode),      32'(m_op));
            check("cyc TX_DATA",     32'(tx_data),     32'(m_txd));
            check("cyc TX_START",    32'(tx_start),    32'(m_post == 2 && tx_ready && !reset));
            check("cyc BUSY",        32'(busy),        32'(m_got != 0 || m_post != 0));
            check("cyc OVERRUN",     32'(overrun),     32'(m_ovr));
            check("cyc TIMEOUT_ERR", 32'(timeout_err), 32'(m_terr));
            if (tx_start) check("TX_START back-to-back", 32'(prev_start), 32'(0));
            prev_start = tx_start;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
    endtask

    // Called at the start of EXEC with TX_READY=1.
    task automatic finish_frame(input logic [7:0] exp, input string name);
        @(negedge clk);
        check({name, " no start in exec"}, 32'(tx_start), 32'(0));
        tick();
        @(negedge clk);
        check({name, " start at n+2"}, 32'(tx_start), 32'(1));
        check({name, " tx data"}, 32'(tx_data), 32'(exp));
        tick();
        @(negedge clk);
        check({name, " idle after send"}, 32'(busy), 32'(0));
        tick();
    endtask

    task automatic frame_run(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                             input logic [7:0] exp, input string name);
        send_byte(a);
        send_byte(b);
        send_byte(op);
        finish_frame(exp, name);
    endtask

    // Called in the first idle cycle of a partial frame.
    task automatic expect_timeout(input string name);
        int pulses = 0;
        int first  = -1;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (timeout_err) begin
                pulses++;
                if (first < 0) first = i;
            end
            tick();
        end
        check({name, " pulse count"}, 32'(pulses), 32'(1));
        check({name, " pulse cycle"}, 32'(first), 32'(TIMEOUT));
    endtask

    initial begin
        reset = 1'b1; rx_valid = 1'b1; rx_data = 8'hFF; tx_ready = 1'b1;
        @(posedge clk); #1;
        en_cmp = 1;
        tick();
        tick();
        @(negedge clk);
        check("reset DATOA", 32'(datoa), 32'(0));
        check("reset TX_DATA", 32'(tx_data), 32'(0));
        check("reset TX_START", 32'(tx_start), 32'(0));
        check("reset BUSY", 32'(busy), 32'(0));
        tick();
        reset = 1'b0; rx_valid = 1'b0;
        tick();

        send_byte(8'h05); send_byte(8'h03); send_byte(8'h20);
        @(negedge clk);
        check("add operand A", 32'(datoa), 32'(8'h05));
        check("add operand B", 32'(datob), 32'(8'h03));
        check("add opcode", 32'(opcode), 32'(6'h20));
        tick();
        @(negedge clk);
        check("add start n+2", 32'(tx_start), 32'(1));
        check("add result", 32'(tx_data), 32'(8'h08));
        tick();
        tick();

        frame_run(8'h03, 8'h05, 8'h22, 8'hFE, "sub");
        frame_run(8'h80, 8'h02, 8'h03, 8'hE0, "sra");
        frame_run(8'h10, 8'h22, 8'hE0, 8'h32, "op upper bits");
        @(negedge clk);
        check("op upper bits opcode", 32'(opcode), 32'(6'h20));
        tick();

        tx_ready = 1'b0;
        send_byte(8'h0A); send_byte(8'h0F); send_byte(8'h24);
        tick();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall no start", 32'(tx_start), 32'(0));
            check("stall busy", 32'(busy), 32'(1));
            tick();
        end
        tx_ready = 1'b1;
        @(negedge clk);
        check("stall release start", 32'(tx_start), 32'(1));
        check("stall result", 32'(tx_data), 32'(8'h0A));
        tick();
        @(negedge clk);
        check("stall back to idle", 32'(busy), 32'(0));
        tick();

        send_byte(8'h11);
        expect_timeout("timeout in B");
        @(negedge clk);
        check("timeout keeps A", 32'(datoa), 32'(8'h11));
        tick();
        frame_run(8'h01, 8'h01, 8'h20, 8'h02, "after timeout");

        send_byte(8'h40); send_byte(8'h41);
        expect_timeout("timeout in OP");
        @(negedge clk);
        check("timeout keeps B", 32'(datob), 32'(8'h41));
        tick();

        send_byte(8'h30);
        repeat (TIMEOUT - 1) tick();
        send_byte(8'h0F);
        send_byte(8'h26);
        finish_frame(8'h3F, "byte at expiry");

        tx_ready = 1'b0;
        send_byte(8'h07); send_byte(8'h02); send_byte(8'h20);
        rx_valid = 1'b1; rx_data = 8'hAA;
        tick();
        rx_data = 8'h55;
        @(negedge clk);
        check("overrun from exec", 32'(overrun), 32'(1));
        tick();
        rx_valid = 1'b0;
        @(negedge clk);
        check("overrun from send", 32'(overrun), 32'(1));
        check("overrun keeps result", 32'(tx_data), 32'(8'h09));
        check("overrun keeps A", 32'(datoa), 32'(8'h07));
        tick();
        @(negedge clk);
        check("overrun one cycle", 32'(overrun), 32'(0));
        tick();
        tx_ready = 1'b1;
        @(negedge clk);
        check("overrun frame start", 32'(tx_start), 32'(1));
        tick();
        tick();

        send_byte(8'h12); send_byte(8'h34);
        reset = 1'b1; rx_valid = 1'b1; rx_data = 8'h20;
        tick();
        reset = 1'b0; rx_valid = 1'b0;
        @(negedge clk);
        check("reset in OP A", 32'(datoa), 32'(0));
        check("reset in OP B", 32'(datob), 32'(0));
        check("reset in OP opcode", 32'(opcode), 32'(0));
        check("reset in OP busy", 32'(busy), 32'(0));
        tick();
        tx_ready = 1'b0;
        send_byte(8'h09); send_byte(8'h01); send_byte(8'h22);
        tick();
        tx_ready = 1'b1; reset = 1'b1;
        @(negedge clk);
        check("reset in SEND no start", 32'(tx_start), 32'(0));
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("reset in SEND tx data", 32'(tx_data), 32'(0));
        check("reset in SEND busy", 32'(busy), 32'(0));
        check("reset in SEND start", 32'(tx_start), 32'(0));
        tick();
        frame_run(8'h06, 8'h07, 8'h20, 8'h0D, "after reset");

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
